// File: rtl/pool2_fmap_pingpong_if.sv
// Pool2 -> next-layer feature-map bus: lane writes, bank hand-off pulses/levels, flat reads.
// master = producer/consumer side (Pool2 + next layer), slave = the ping-pong buffer.
interface pool2_fmap_pingpong_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE          = 5,
  parameter int IFM_DEPTH         = 16,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int SEL_WIDTH         = $clog2(IFM_DEPTH/NUMBER_OF_UNITS+1),
  parameter int ADDRESS_SIZE_READ = $clog2(IFM_DEPTH*IFM_SIZE*IFM_SIZE)
);
  logic                         ifm_enable_write_previous;
  logic [ADDRESS_SIZE_IFM-1:0]  ifm_address_write_previous;
  logic [SEL_WIDTH-1:0]         ifm_sel_previous;
  logic [DATA_WIDTH-1:0]        data_in_1;
  logic [DATA_WIDTH-1:0]        data_in_2;
  logic [DATA_WIDTH-1:0]        data_in_3;
  logic                         start_from_previous;
  logic                         end_to_previous;
  logic                         start_to_next;
  logic                         end_from_next;
  logic                         ifm_enable_read_next;
  logic [ADDRESS_SIZE_READ-1:0] ifm_address_read_next;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         data_valid;
  logic                         overflow;

  modport master (
    output ifm_enable_write_previous, ifm_address_write_previous, ifm_sel_previous,
    output data_in_1, data_in_2, data_in_3, start_from_previous,
    output end_from_next, ifm_enable_read_next, ifm_address_read_next,
    input  end_to_previous, start_to_next, data_out, data_valid, overflow
  );

  modport slave (
    input  ifm_enable_write_previous, ifm_address_write_previous, ifm_sel_previous,
    input  data_in_1, data_in_2, data_in_3, start_from_previous,
    input  end_from_next, ifm_enable_read_next, ifm_address_read_next,
    output end_to_previous, start_to_next, data_out, data_valid, overflow
  );
endinterface

// File: rtl/pool2_fmap_pingpong.sv
// Two-bank ping-pong feature-map buffer between Pool2 and the next layer; reads 1-cycle registered.
// Backpressure via end_to_previous/start_to_next levels; writes/handshakes violating them are dropped and flag overflow.
module pool2_fmap_pingpong #(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE          = 5,
  parameter int IFM_DEPTH         = 16,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int SEL_WIDTH         = $clog2(IFM_DEPTH/NUMBER_OF_UNITS+1),
  parameter int ADDRESS_SIZE_READ = $clog2(IFM_DEPTH*IFM_SIZE*IFM_SIZE)
) (
  input logic                 clk,
  input logic                 reset,
  pool2_fmap_pingpong_if.slave bus
);
  localparam int PIX        = IFM_SIZE * IFM_SIZE;
  localparam int VOL        = IFM_DEPTH * PIX;
  localparam int GROUPS     = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int LANE_WORDS = 2 * GROUPS * PIX;
  localparam int IDX_W      = $clog2(LANE_WORDS);
  localparam int LANE_W     = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;

  // One RAM per write lane: lane k owns maps k, k+3, ... so each lane needs a single write port.
  logic [DATA_WIDTH-1:0] lane_mem [NUMBER_OF_UNITS][LANE_WORDS];
  logic [DATA_WIDTH-1:0] lane_dat [NUMBER_OF_UNITS];

  logic                         wb;
  logic                         rb;
  logic [1:0]                   full_count;
  logic [DATA_WIDTH-1:0]        data_out_q;
  logic                         data_valid_q;
  logic                         overflow_q;

  logic [ADDRESS_SIZE_IFM-1:0]  wr_addr;
  logic [SEL_WIDTH-1:0]         wr_sel;
  logic [ADDRESS_SIZE_READ-1:0] rd_addr;
  logic [NUMBER_OF_UNITS-1:0]   wr_en;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic [LANE_W-1:0]            rd_lane;
  logic                         rd_in_range;
  logic                         rel;
  logic                         acq;
  logic                         proto_err;
  int                           rd_flat;
  int                           rd_map;

  assign wr_addr     = bus.ifm_address_write_previous;
  assign wr_sel      = bus.ifm_sel_previous;
  assign rd_addr     = bus.ifm_address_read_next;
  assign lane_dat[0] = bus.data_in_1;
  assign lane_dat[1] = bus.data_in_2;
  assign lane_dat[2] = bus.data_in_3;

  always_comb begin
    wr_idx = IDX_W'((int'(wb) * GROUPS + int'(wr_sel)) * PIX + int'(wr_addr));
    wr_en  = '0;
    for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
      wr_en[k] = bus.ifm_enable_write_previous && !reset && (full_count != 2'd2) &&
                 (int'(wr_addr) < PIX) &&
                 (int'(wr_sel) * NUMBER_OF_UNITS + k < IFM_DEPTH);
    end
  end

  always_comb begin
    rd_flat     = int'(rd_addr);
    rd_map      = rd_flat / PIX;
    rd_in_range = rd_flat < VOL;
    rd_lane     = LANE_W'(rd_map % NUMBER_OF_UNITS);
    rd_idx      = IDX_W'((int'(rb) * GROUPS + rd_map / NUMBER_OF_UNITS) * PIX + rd_flat % PIX);
  end

  // Release is evaluated first so a full buffer can accept a new volume in the same cycle it frees one.
  always_comb begin
    rel       = bus.end_from_next && (full_count != 2'd0);
    acq       = bus.start_from_previous && ((full_count != 2'd2) || rel);
    proto_err = (bus.end_from_next && !rel) ||
                (bus.start_from_previous && !acq) ||
                (bus.ifm_enable_write_previous && (full_count == 2'd2));
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
      if (wr_en[k]) lane_mem[k][wr_idx] <= lane_dat[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb           <= 1'b0;
      rb           <= 1'b0;
      full_count   <= 2'd0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (acq) wb <= ~wb;
      if (rel) rb <= ~rb;
      if (acq && !rel)      full_count <= full_count + 2'd1;
      else if (rel && !acq) full_count <= full_count - 2'd1;
      if (proto_err) overflow_q <= 1'b1;
      data_valid_q <= bus.ifm_enable_read_next;
      if (bus.ifm_enable_read_next) begin
        data_out_q <= rd_in_range ? lane_mem[rd_lane][rd_idx] : '0;
      end
    end
  end

  assign bus.end_to_previous = (full_count < 2'd2);
  assign bus.start_to_next   = (full_count > 2'd0);
  assign bus.data_out        = data_out_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_pool2_fmap_pingpong.sv
// Bench for pool2_fmap_pingpong: directed sequences, handshake table and random traffic vs a bank/map array model.
module tb_pool2_fmap_pingpong;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool2_fmap_pingpong_if bus();
  pool2_fmap_pingpong dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rst, we, st, en, re;
    logic [4:0]  wa;
    logic [2:0]  sel;
    logic [31:0] d1, d2, d3;
    logic [8:0]  ra;
  } in_t;

  typedef struct {
    in_t  i;
    logic e2p, s2n, ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference state: two volumes of 16 maps x 25 pixels, plus ownership pointers and fill count.
  logic [31:0] m_mem [2][16][25];
  logic        m_wb, m_rb, m_ovf, m_dvld;
  int          m_cnt;
  logic [31:0] m_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic in_t idle_in();
    in_t r;
    r.rst = 0; r.we = 0; r.st = 0; r.en = 0; r.re = 0;
    r.wa = 0; r.sel = 0; r.d1 = 0; r.d2 = 0; r.d3 = 0; r.ra = 0;
    return r;
  endfunction

  task automatic model(input in_t i);
    logic rel, acq;
    int a, m;
    logic [31:0] lane [3];
    if (i.rst) begin
      m_wb = 0; m_rb = 0; m_cnt = 0; m_ovf = 0; m_dout = 0; m_dvld = 0;
      return;
    end
    m_dvld = i.re;
    if (i.re) begin
      a = int'(i.ra);
      m_dout = (a < 400) ? m_mem[m_rb][a / 25][a % 25] : 32'd0;
    end
    lane[0] = i.d1; lane[1] = i.d2; lane[2] = i.d3;
    if (i.we) begin
      if (m_cnt == 2) m_ovf = 1;
      else if (int'(i.wa) < 25) begin
        for (int k = 0; k < 3; k++) begin
          m = int'(i.sel) * 3 + k;
          if (m < 16) m_mem[m_wb][m][i.wa] = lane[k];
        end
      end
    end
    rel = i.en && (m_cnt > 0);
    acq = i.st && ((m_cnt < 2) || rel);
    if ((i.en && !rel) || (i.st && !acq)) m_ovf = 1;
    if (rel) begin m_rb = ~m_rb; m_cnt--; end
    if (acq) begin m_wb = ~m_wb; m_cnt++; end
  endtask

  task automatic step(input in_t i);
    reset                          = i.rst;
    bus.ifm_enable_write_previous  = i.we;
    bus.ifm_address_write_previous = i.wa;
    bus.ifm_sel_previous           = i.sel;
    bus.data_in_1                  = i.d1;
    bus.data_in_2                  = i.d2;
    bus.data_in_3                  = i.d3;
    bus.start_from_previous        = i.st;
    bus.end_from_next              = i.en;
    bus.ifm_enable_read_next       = i.re;
    bus.ifm_address_read_next      = i.ra;
    model(i);
    @(posedge clk);
    #1;
    chk("end_to_previous", 32'(bus.end_to_previous), 32'(m_cnt < 2));
    chk("start_to_next",   32'(bus.start_to_next),   32'(m_cnt > 0));
    chk("overflow",        32'(bus.overflow),        32'(m_ovf));
    chk("data_valid",      32'(bus.data_valid),      32'(m_dvld));
    chk("data_out",        bus.data_out,             m_dout);
  endtask

  task automatic do_idle();
    step(idle_in());
  endtask

  task automatic do_reset();
    in_t r = idle_in();
    r.rst = 1;
    step(r);
  endtask

  task automatic do_pulse(input logic st, input logic en);
    in_t r = idle_in();
    r.st = st; r.en = en;
    step(r);
  endtask

  task automatic do_write(input int sel, input int addr, input int d1, input int d2, input int d3);
    in_t r = idle_in();
    r.we = 1; r.sel = 3'(sel); r.wa = 5'(addr);
    r.d1 = 32'(d1); r.d2 = 32'(d2); r.d3 = 32'(d3);
    step(r);
  endtask

  task automatic fill(input int base);
    for (int s = 0; s < 6; s++)
      for (int a = 0; a < 25; a++)
        do_write(s, a, base + (s*3)*100 + a, base + (s*3+1)*100 + a, base + (s*3+2)*100 + a);
  endtask

  task automatic rd_expect(input string nm, input int addr, input int value);
    in_t r = idle_in();
    r.re = 1; r.ra = 9'(addr);
    step(r);
    chk(nm, bus.data_out, 32'(value));
    chk({nm, "_valid"}, 32'(bus.data_valid), 32'd1);
  endtask

  function automatic vec_t mk(input logic rst, input logic st, input logic en,
                              input logic e2p, input logic s2n, input logic ovf);
    vec_t v;
    v.i = idle_in();
    v.i.rst = rst; v.i.st = st; v.i.en = en;
    v.e2p = e2p; v.s2n = s2n; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    vec_t tbl [12];
    in_t  r;
    tbl[0]  = mk(1, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 0, 1, 1, 0);
    tbl[11] = mk(0, 1, 1, 1, 1, 0);

    // Reset then idle.
    do_reset();
    do_idle();
    chk("rst_e2p", 32'(bus.end_to_previous), 32'd1);
    chk("rst_s2n", 32'(bus.start_to_next), 32'd0);
    chk("rst_dout", bus.data_out, 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);

    // Fill one volume, hand it off, read it back.
    fill(0);
    do_pulse(1, 0);
    chk("s2n_after_start", 32'(bus.start_to_next), 32'd1);
    rd_expect("rd399", 399, 1524);
    rd_expect("rd26", 26, 101);
    rd_expect("rd200", 200, 800);
    do_idle();
    chk("hold_valid", 32'(bus.data_valid), 32'd0);
    chk("hold_dout", bus.data_out, 32'd800);

    // Both banks full, then a dropped write and a dropped start.
    fill(10000);
    do_pulse(1, 0);
    chk("full_e2p", 32'(bus.end_to_previous), 32'd0);
    do_write(0, 0, 777, 777, 777);
    chk("ovf_write", 32'(bus.overflow), 32'd1);
    do_pulse(1, 0);
    rd_expect("b0_rd0", 0, 0);
    rd_expect("b0_rd399", 399, 1524);
    do_pulse(0, 1);
    chk("after_end_e2p", 32'(bus.end_to_previous), 32'd1);
    chk("after_end_s2n", 32'(bus.start_to_next), 32'd1);
    rd_expect("b1_rd0", 0, 10000);
    rd_expect("b1_rd399", 399, 11524);
    rd_expect("b1_rd100", 100, 10400);
    do_pulse(0, 1);

    // Simultaneous release and acquire with one bank full.
    do_reset();
    fill(20000);
    do_pulse(1, 0);
    rd_expect("sim_rd_b0", 5, 20005);
    fill(30000);
    do_pulse(1, 1);
    chk("sim_s2n", 32'(bus.start_to_next), 32'd1);
    chk("sim_e2p", 32'(bus.end_to_previous), 32'd1);
    rd_expect("sim_rd_b1", 5, 30005);
    rd_expect("sim_rd_b1_399", 399, 31524);

    // Release with nothing full; out-of-range read.
    do_pulse(0, 1);
    do_pulse(0, 1);
    chk("ovf_end_empty", 32'(bus.overflow), 32'd1);
    rd_expect("rd400", 400, 0);

    // Reset mid-fill with one volume outstanding.
    do_reset();
    fill(40000);
    do_pulse(1, 0);
    do_write(0, 0, 1, 2, 3);
    do_write(0, 1, 4, 5, 6);
    do_reset();
    chk("mid_rst_e2p", 32'(bus.end_to_previous), 32'd1);
    chk("mid_rst_s2n", 32'(bus.start_to_next), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_rst_dout", bus.data_out, 32'd0);
    chk("mid_rst_dvld", 32'(bus.data_valid), 32'd0);
    fill(50000);
    do_pulse(1, 0);
    rd_expect("post_rst_rd399", 399, 51524);
    rd_expect("post_rst_rd0", 0, 50000);

    // Handshake table.
    for (int n = 0; n < 12; n++) begin
      step(tbl[n].i);
      chk($sformatf("tbl%0d_e2p", n), 32'(bus.end_to_previous), 32'(tbl[n].e2p));
      chk($sformatf("tbl%0d_s2n", n), 32'(bus.start_to_next), 32'(tbl[n].s2n));
      chk($sformatf("tbl%0d_ovf", n), 32'(bus.overflow), 32'(tbl[n].ovf));
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r     = idle_in();
      r.rst = ($urandom_range(0, 399) == 0);
      r.we  = ($urandom_range(0, 1) == 0);
      r.wa  = 5'($urandom_range(0, 31));
      r.sel = 3'($urandom_range(0, 7));
      r.d1  = $urandom;
      r.d2  = $urandom;
      r.d3  = $urandom;
      r.st  = ($urandom_range(0, 24) == 0);
      r.en  = ($urandom_range(0, 24) == 0);
      r.re  = ($urandom_range(0, 1) == 0);
      r.ra  = 9'($urandom_range(0, 511));
      step(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
